// File: rtl/mdu_sequencer_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op encoding,
// sequencer states, special-case result constants and op-class helpers.
package riscv_defines;

    localparam int MDU_OP_WIDTH = 3;

    // Encoding follows the RV32M funct3 field.
    typedef enum logic [MDU_OP_WIDTH-1:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    localparam logic [31:0] DIV_ZERO_Q = '1;
    localparam logic [31:0] DIV_OVF_Q  = 32'h8000_0000;

    function automatic logic isDivOp(input mdu_op_e op);
        return op[2];
    endfunction

    function automatic logic isRemOp(input mdu_op_e op);
        return op[2] & op[1];
    endfunction

    // Operand A is two's complement for every signed op, including MULHSU.
    function automatic logic signedA(input mdu_op_e op);
        return op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
    endfunction

    // MULHSU treats operand B as unsigned.
    function automatic logic signedB(input mdu_op_e op);
        return op inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
    endfunction

endpackage

// File: rtl/mdu_shift_datapath.sv
// Accumulators and single-step shift-add multiply / restoring divide.
// Operands are held as magnitudes with sign flags; the final step and the
// sign correction are folded into the combinational result used in FIX.
module mdu_shift_datapath
    import riscv_defines::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic                  step_i,
    input  mdu_op_e               op_i,
    input  logic [WORD_WIDTH-1:0] rs1_i,
    input  logic [WORD_WIDTH-1:0] rs2_i,
    output logic                  special_o,
    output logic [WORD_WIDTH-1:0] specialResult_o,
    output logic [WORD_WIDTH-1:0] result_o
);

    localparam int W = WORD_WIDTH;
    localparam logic [W-1:0] MIN_VALUE = {1'b1, {(W-1){1'b0}}};

    mdu_op_e        op_q;
    logic           negA_q, negB_q;
    logic [W-1:0]   operand_q;
    logic [W-1:0]   accHi_q, accLo_q;

    logic           negA, negB;
    logic [W-1:0]   magA, magB;
    logic [W:0]     mulSum;
    logic [W:0]     remShift;
    logic           remGe;
    logic [W-1:0]   stepHi, stepLo;
    logic [2*W-1:0] product, prodFixed;
    logic [W-1:0]   quotFixed, remFixed;

    // Operand magnitudes and sign flags taken straight from the inputs
    always_comb begin
        negA = signedA(op_i) & rs1_i[W-1];
        negB = signedB(op_i) & rs2_i[W-1];
        magA = negA ? -rs1_i : rs1_i;
        magB = negB ? -rs2_i : rs2_i;
    end

    // Divide-by-zero and signed overflow resolve without iterating
    always_comb begin
        special_o       = 1'b0;
        specialResult_o = '0;
        if (isDivOp(op_i)) begin
            if (rs2_i == '0) begin
                special_o       = 1'b1;
                specialResult_o = isRemOp(op_i) ? rs1_i : '1;
            end else if (signedB(op_i) && rs1_i == MIN_VALUE && rs2_i == '1) begin
                special_o       = 1'b1;
                specialResult_o = isRemOp(op_i) ? '0 : MIN_VALUE;
            end
        end
    end

    // One multiply or divide iteration computed from the current accumulators
    always_comb begin
        mulSum   = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, operand_q} : '0);
        remShift = {accHi_q, accLo_q[W-1]};
        remGe    = remShift >= {1'b0, operand_q};
        if (isDivOp(op_q)) begin
            stepHi = remGe ? W'(remShift - {1'b0, operand_q}) : remShift[W-1:0];
            stepLo = {accLo_q[W-2:0], remGe};
        end else begin
            stepHi = mulSum[W:1];
            stepLo = {mulSum[0], accLo_q[W-1:1]};
        end
    end

    // Sign correction and result selection on top of the final iteration
    always_comb begin
        product   = {stepHi, stepLo};
        prodFixed = (negA_q ^ negB_q) ? -product : product;
        quotFixed = (negA_q ^ negB_q) ? -stepLo : stepLo;
        remFixed  = negA_q ? -stepHi : stepHi;
        unique case (op_q)
            MDU_MUL:                        result_o = prodFixed[W-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: result_o = prodFixed[2*W-1:W];
            MDU_DIV, MDU_DIVU:              result_o = quotFixed;
            default:                        result_o = remFixed;
        endcase
    end

    // Latch operands on acceptance, then advance one step per CALC cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q      <= MDU_MUL;
            negA_q    <= 1'b0;
            negB_q    <= 1'b0;
            operand_q <= '0;
            accHi_q   <= '0;
            accLo_q   <= '0;
        end else if (load_i) begin
            op_q      <= op_i;
            negA_q    <= negA;
            negB_q    <= negB;
            operand_q <= isDivOp(op_i) ? magB : magA;
            accHi_q   <= '0;
            accLo_q   <= isDivOp(op_i) ? magA : magB;
        end else if (step_i) begin
            accHi_q   <= stepHi;
            accLo_q   <= stepLo;
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide unit: handshake, sequencing FSM,
// iteration counter, flush handling and the registered result.
module mdu_sequencer
    import riscv_defines::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int ITERATIONS = WORD_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [MDU_OP_WIDTH-1:0] op_i,
    input  logic [WORD_WIDTH-1:0]   rs1_i,
    input  logic [WORD_WIDTH-1:0]   rs2_i,
    input  logic                    flush_i,
    output logic                    busy_o,
    output logic                    valid_o,
    output logic [WORD_WIDTH-1:0]   result_o
);

    localparam int CW = $clog2(ITERATIONS + 1);

    mdu_state_e            state_q, state_d;
    logic [CW-1:0]         counter_q, counter_d, counterInc;
    logic [WORD_WIDTH-1:0] pending_q, pending_d;
    logic [WORD_WIDTH-1:0] result_q, result_d;
    logic                  load, step;
    logic                  special;
    logic [WORD_WIDTH-1:0] specialResult, dpResult;

    mdu_shift_datapath #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_datapath (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .load_i         (load),
        .step_i         (step),
        .op_i           (mdu_op_e'(op_i)),
        .rs1_i          (rs1_i),
        .rs2_i          (rs2_i),
        .special_o      (special),
        .specialResult_o(specialResult),
        .result_o       (dpResult)
    );

    // The DONE pulse shows the pending result; a flush hides both
    assign ready_o  = (state_q == ST_IDLE);
    assign busy_o   = (state_q != ST_IDLE);
    assign valid_o  = (state_q == ST_DONE) && !flush_i;
    assign result_o = valid_o ? pending_q : result_q;

    // Next-state, counter and datapath control
    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        pending_d  = pending_q;
        result_d   = result_q;
        load       = 1'b0;
        step       = 1'b0;
        counterInc = counter_q + CW'(1);
        unique case (state_q)
            ST_IDLE: begin
                if (valid_i && !flush_i) begin
                    load      = 1'b1;
                    counter_d = '0;
                    if (special) begin
                        pending_d = specialResult;
                        state_d   = ST_DONE;
                    end else begin
                        state_d   = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    step      = 1'b1;
                    counter_d = counterInc;
                    if (counterInc == CW'(ITERATIONS - 1)) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    pending_d = dpResult;
                    state_d   = ST_DONE;
                end
            end
            default: begin
                if (!flush_i) begin
                    result_d = pending_q;
                end
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and result registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            counter_q <= '0;
            pending_q <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            pending_q <= pending_d;
            result_q  <= result_d;
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Randomized and directed bench for mdu_sequencer against an arithmetic
// reference model of the RV32M multiply/divide instructions.
module tb_mdu_sequencer;

    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;
    localparam logic [31:0] MIN32 = 32'h8000_0000;
    localparam int NORMAL_LATENCY = 33;
    localparam int TIMEOUT = 100;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [2:0]  op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        flush_i;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] result_o;

    int          assertCount = 0;
    int          failCount = 0;
    logic [31:0] lastResult = '0;

    mdu_sequencer dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .op_i    (op_i),
        .rs1_i   (rs1_i),
        .rs2_i   (rs2_i),
        .flush_i (flush_i),
        .busy_o  (busy_o),
        .valid_o (valid_o),
        .result_o(result_o)
    );

    // Free-running clock
    always #5 clk_i = ~clk_i;

    // Reference: the instruction results written as plain arithmetic
    function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ub = longint'({32'b0, b});
        logic [63:0] p;
        case (op)
            OP_MUL:    begin p = sa * sb; return p[31:0]; end
            OP_MULH:   begin p = sa * sb; return p[63:32]; end
            OP_MULHSU: begin p = sa * ub; return p[63:32]; end
            OP_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            OP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN32 && b == 32'hFFFF_FFFF) return MIN32;
                return 32'($signed(a) / $signed(b));
            end
            OP_DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            OP_REM: begin
                if (b == 0) return a;
                if (a == MIN32 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'($signed(a) % $signed(b));
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit isSpecial(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op < OP_DIV) return 1'b0;
        if (b == 0) return 1'b1;
        return (op == OP_DIV || op == OP_REM) && a == MIN32 && b == 32'hFFFF_FFFF;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    // Present one operation for a single cycle, then scramble the inputs
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        valid_i = 1'b1;
        op_i    = op;
        rs1_i   = a;
        rs2_i   = b;
        nextCycle();
        valid_i = 1'b0;
        op_i    = 3'($urandom_range(0, 7));
        rs1_i   = $urandom;
        rs2_i   = $urandom;
    endtask

    // Wait for the result pulse from cycle 1 and check it against the model
    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] expected;
        int          cyc;
        bit          busyBad;
        expected = refModel(op, a, b);
        busyBad  = 1'b0;
        applyStimulus(op, a, b);
        cyc = 1;
        while (!valid_o && cyc < TIMEOUT) begin
            if (!busy_o || ready_o) busyBad = 1'b1;
            nextCycle();
            cyc++;
        end
        if (!busy_o || ready_o) busyBad = 1'b1;
        checkOutput($sformatf("latency op%0d", op), 64'(cyc), isSpecial(op, a, b) ? 64'd1 : 64'(NORMAL_LATENCY));
        checkOutput($sformatf("result op%0d %h,%h", op, a, b), {32'b0, result_o}, {32'b0, expected});
        checkOutput("busy during op", {63'b0, busyBad}, 64'd0);
        nextCycle();
        checkOutput("valid pulse width", {63'b0, valid_o}, 64'd0);
        checkOutput("result hold", {32'b0, result_o}, {32'b0, expected});
        checkOutput("ready after done", {63'b0, ready_o}, 64'd1);
        lastResult = expected;
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return MIN32;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit sawValid;
        rst_i   = 1'b1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        op_i    = '0;
        rs1_i   = '0;
        rs2_i   = '0;
        #2;
        checkOutput("reset ready", {63'b0, ready_o}, 64'd1);
        checkOutput("reset busy", {63'b0, busy_o}, 64'd0);
        checkOutput("reset valid", {63'b0, valid_o}, 64'd0);
        checkOutput("reset result", {32'b0, result_o}, 64'd0);
        nextCycle();
        nextCycle();
        rst_i = 1'b0;

        $display("[TB] directed operations");
        runOp(OP_MUL, 32'd7, 32'hFFFF_FFFD);
        runOp(OP_MULH, MIN32, MIN32);
        runOp(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        runOp(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        runOp(OP_DIVU, 32'd100, 32'd7);
        runOp(OP_REMU, 32'd100, 32'd7);
        runOp(OP_DIV, -32'sd100, 32'd7);
        runOp(OP_REM, -32'sd100, 32'd7);
        runOp(OP_DIV, 32'd5, 32'd0);
        runOp(OP_REM, 32'd5, 32'd0);
        runOp(OP_DIV, MIN32, 32'hFFFF_FFFF);
        runOp(OP_REM, MIN32, 32'hFFFF_FFFF);
        runOp(OP_DIVU, MIN32, 32'hFFFF_FFFF);

        $display("[TB] flush during CALC");
        sawValid = 1'b0;
        applyStimulus(OP_MUL, 32'd123, 32'd456);
        for (int c = 1; c < 10; c++) begin
            if (valid_o) sawValid = 1'b1;
            nextCycle();
        end
        flush_i = 1'b1;
        #1;
        if (valid_o) sawValid = 1'b1;
        nextCycle();
        flush_i = 1'b0;
        checkOutput("flush no valid", {63'b0, sawValid}, 64'd0);
        checkOutput("flush ready", {63'b0, ready_o}, 64'd1);
        checkOutput("flush result kept", {32'b0, result_o}, {32'b0, lastResult});
        runOp(OP_DIVU, 32'd1000, 32'd33);

        $display("[TB] flush with valid in IDLE");
        valid_i = 1'b1;
        flush_i = 1'b1;
        op_i    = OP_MUL;
        rs1_i   = 32'd3;
        rs2_i   = 32'd3;
        nextCycle();
        valid_i = 1'b0;
        flush_i = 1'b0;
        checkOutput("flush blocks accept", {63'b0, ready_o}, 64'd1);

        $display("[TB] flush in DONE");
        applyStimulus(OP_DIVU, 32'd77, 32'd0);
        flush_i = 1'b1;
        #1;
        checkOutput("done flush valid", {63'b0, valid_o}, 64'd0);
        checkOutput("done flush result", {32'b0, result_o}, {32'b0, lastResult});
        nextCycle();
        flush_i = 1'b0;
        checkOutput("done flush idle", {63'b0, ready_o}, 64'd1);
        checkOutput("done flush result after", {32'b0, result_o}, {32'b0, lastResult});

        $display("[TB] reset mid-CALC");
        applyStimulus(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678);
        for (int c = 1; c < 15; c++) nextCycle();
        rst_i = 1'b1;
        #1;
        checkOutput("midreset ready", {63'b0, ready_o}, 64'd1);
        checkOutput("midreset busy", {63'b0, busy_o}, 64'd0);
        checkOutput("midreset valid", {63'b0, valid_o}, 64'd0);
        checkOutput("midreset result", {32'b0, result_o}, 64'd0);
        nextCycle();
        rst_i = 1'b0;
        lastResult = '0;
        sawValid = 1'b0;
        for (int c = 0; c < 25; c++) begin
            if (valid_o || busy_o) sawValid = 1'b1;
            nextCycle();
        end
        checkOutput("midreset stays idle", {63'b0, sawValid}, 64'd0);

        $display("[TB] random back-to-back operations");
        for (int n = 0; n < 40; n++) begin
            runOp(3'($urandom_range(0, 7)), pickOperand(), pickOperand());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Iterative RV32M multiply/divide unit with its own sequencing FSM.
- Sits beside the ALU in execute. It takes the MDU op from the control unit and both register operands, runs a radix-2 shift-add multiply or a restoring divide, and stalls the pipeline until the result is ready.
- Division-by-zero and signed-overflow cases bypass iteration and resolve in one cycle.

Parameters:
- WORD_WIDTH, 32, operand/result width.
- ITERATIONS, WORD_WIDTH, number of shift steps per multiply or divide.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  asynchronous, active-high reset.
- valid_i  in  1  an MDU operation is presented this cycle.
- ready_o  out  1  block is idle and can accept an operation.
- op_i  in  3  mdu_op_e: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- rs1_i  in  WORD_WIDTH  operand A (multiplicand/dividend).
- rs2_i  in  WORD_WIDTH  operand B (multiplier/divisor).
- flush_i  in  1  abort any operation in flight.
- busy_o  out  1  operation in flight; the pipeline stalls on this.
- valid_o  out  1  one-cycle pulse, result_o is valid.
- result_o  out  WORD_WIDTH  result of the completed operation.

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is asynchronous and active-high.
- Reset values: state IDLE, ready_o=1, busy_o=0, valid_o=0, result_o=0, counter=0.
- States: IDLE, CALC, FIX, DONE.
  - ready_o = (state==IDLE).
  - busy_o = (state!=IDLE).
- Acceptance: an operation is accepted on the edge where valid_i & ready_o & !flush_i.
  - op, rs1 and rs2 are latched at that edge. Later input changes are ignored.
  - Signed ops store operand magnitudes plus sign flags. MULHSU treats rs2 as unsigned.
- IDLE -> DONE: on acceptance of a special case:
  - DIV/DIVU with rs2==0: quotient = all ones.
  - REM/REMU with rs2==0: result = rs1.
  - DIV with rs1=0x80000000, rs2=0xFFFFFFFF: result = 0x80000000.
  - REM with the same operands: result = 0.
- IDLE -> CALC: on any other acceptance; counter cleared to 0.
- CALC: one shift step per cycle.
  - Multiply: 2*WORD_WIDTH-bit product accumulator.
  - Divide: restoring subtract-and-shift on a WORD_WIDTH+1-bit partial remainder.
  - Counter increments each cycle. When counter==ITERATIONS-1 the next state is FIX.
- FIX: one cycle applying sign correction and selecting the result.
  - Product low half for MUL, high half for MULH*.
  - Quotient for DIV*, remainder for REM*.
  - Quotient sign = sign(A) xor sign(B). Remainder takes the sign of the dividend.
- DONE: valid_o=1 for exactly this cycle; result_o is registered. Next state is IDLE.
  - result_o holds its value until the next DONE or reset.
- Latency, counted from the acceptance edge:
  - Normal ops: ITERATIONS+1 edges to reach DONE, so valid_o is high in cycle 33 for WORD_WIDTH=32.
  - Special cases: valid_o is high in cycle 1.
- Flush:
  - flush_i in CALC, FIX or DONE forces IDLE on the next edge. valid_o is suppressed that cycle and result_o is unchanged.
  - flush_i together with valid_i in IDLE: the operation is not accepted.
- Back-to-back: a new operation can be accepted in the cycle immediately after DONE (IDLE, ready_o=1).
- Reset mid-operation: immediate return to IDLE with the reset values above. No valid_o is produced.

Decomposition:
- Shared package (riscv_defines):
  - mdu_op_e enum.
  - MDU_OP_WIDTH=3.
  - Special-case constants: DIV_ZERO_Q = '1, DIV_OVF_Q = 32'h80000000.
- Sub-module mdu_shift_datapath: the accumulators, sign handling and single-step multiply/divide logic.
  - mdu_sequencer keeps the FSM, counter, handshake and flush/reset.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> valid_o at cycle 33, result_o=0xFFFFFFEB; busy_o high cycles 1-33, ready_o low.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIV -100/7 -> 0xFFFFFFF2; REM -100/7 -> 0xFFFFFFFE; each valid_o at cycle 33.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, valid_o at cycle 1. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, valid_o at cycle 1.
- Flush: accept MUL, flush_i at cycle 10 -> no valid_o, ready_o=1 at cycle 11, result_o unchanged; a new DIVU accepted at cycle 11 completes normally.
- Reset: rst_i asserted mid-CALC at cycle 15 -> outputs at reset values immediately, no valid_o; back-to-back ops after DONE accepted without a gap cycle.
